// File: rtl/pipe_lca_accum.sv
// pipe_lca_accum: pipelined carry-lookahead accumulator (first-order DDSM stage).
// WIDTH bits are split into NSEG = WIDTH/SEG lookahead segments, each with its
// own sum register. The registered carry of segment k feeds segment k+1 one
// enabled cycle later. Input slices are skewed and sum slices are deskewed so
// that o_acc and o_carry belong to the same sample.
// Optional build macro: PIPE_LCA_DITHER_EN adds a 15-bit LFSR (x^15+x^14+1)
// whose bit 0 is injected as the segment-0 carry-in.
module pipe_lca_accum #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_carry,
    output logic             o_valid
);

    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    // Group carries from generate/propagate, each carry a flat sum of products
    // so all carries of the group resolve in parallel.
    function automatic logic [SEG:0] lca_carry(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           term;
        logic           pp;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SEG; i++) begin
            term = g[i];
            pp   = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                term = term | (pp & g[i-1-j]);
                pp   = pp & p[i-1-j];
            end
            c[i+1] = term | (pp & cin);
        end
        return c;
    endfunction

    logic             dither;
    logic [NSEG-1:0]  cout_w;
    logic [WIDTH-1:0] acc_w;

`ifdef PIPE_LCA_DITHER_EN
    logic [14:0] lfsr_q;

    // Dither LFSR, restarts from its seed on reset and advances per enabled sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= 15'h0001;
        end else if (i_en) begin
            lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    assign dither = lfsr_q[0];
`else
    assign dither = 1'b0;
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG-1:0] x_k;
        logic [SEG-1:0] sum_q;
        logic [SEG-1:0] sum_d;
        logic           cin_k;
        logic           carry_q;
        logic           carry_d;
        logic [SEG:0]   c_k;

        if (k == 0) begin : g_noskew
            assign x_k   = i_x[SEG-1:0];
            assign cin_k = dither;
        end else begin : g_skew
            logic [SEG-1:0] skew_q [k];

            // Input skew: delay this segment's slice of i_x by k enabled cycles.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    skew_q <= '{default: '0};
                end else if (i_en) begin
                    skew_q[0] <= i_x[k*SEG +: SEG];
                    for (int unsigned j = 1; j < k; j++) begin
                        skew_q[j] <= skew_q[j-1];
                    end
                end
            end

            assign x_k   = skew_q[k-1];
            assign cin_k = cout_w[k-1];
        end

        // Segment adder: lookahead carries, sum = a ^ b ^ carry-in per bit.
        always_comb begin
            c_k     = lca_carry(sum_q, x_k, cin_k);
            sum_d   = sum_q ^ x_k ^ c_k[SEG-1:0];
            carry_d = c_k[SEG];
        end

        // Segment sum and carry-out registers.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (i_en) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign cout_w[k] = carry_q;

        if (k == NSEG - 1) begin : g_nodeskew
            assign acc_w[k*SEG +: SEG] = sum_q;
        end else begin : g_deskew
            localparam int D = NSEG - 1 - k;
            logic [SEG-1:0] dsk_q [D];

            // Output deskew: hold this slice until the top segment catches up.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    dsk_q <= '{default: '0};
                end else if (i_en) begin
                    dsk_q[0] <= sum_q;
                    for (int unsigned j = 1; j < D; j++) begin
                        dsk_q[j] <= dsk_q[j-1];
                    end
                end
            end

            assign acc_w[k*SEG +: SEG] = dsk_q[D-1];
        end
    end

    logic [CW-1:0] fill_q;
    logic          valid_q;

    // Fill counter: valid after NSEG enabled cycles, sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_en && !valid_q) begin
            if (fill_q == CW'(NSEG - 1)) begin
                valid_q <= 1'b1;
            end else begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign o_acc   = acc_w;
    assign o_carry = cout_w[NSEG-1];
    assign o_valid = valid_q;

endmodule

// File: tb/tb_pipe_lca_accum.sv
// Directed testbench for pipe_lca_accum (WIDTH=16, SEG=4).
module tb_pipe_lca_accum;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] x;
    logic [W-1:0] acc;
    logic         carry;
    logic         valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_acc;
    logic [14:0]  m_lfsr;
    int           e;
    logic [W-1:0] q_acc[$];
    logic         q_car[$];

    always #5 clk = ~clk;

    pipe_lca_accum #(.WIDTH(W), .SEG(S)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_x    (x),
        .o_acc  (acc),
        .o_carry(carry),
        .o_valid(valid)
    );

    task automatic clear_model();
        m_acc  = '0;
        m_lfsr = 15'h0001;
        e      = 0;
        q_acc.delete();
        q_car.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        x   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    // One clock with the given inputs; the model advances on enabled cycles only.
    task automatic cyc(input logic [W-1:0] xv, input logic ev);
        logic [W:0] s;
        logic       d;
        x  = xv;
        en = ev;
        @(posedge clk);
        #1;
        if (ev) begin
            d = 1'b0;
`ifdef PIPE_LCA_DITHER_EN
            d      = m_lfsr[0];
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
`endif
            s     = {1'b0, m_acc} + {1'b0, xv} + (W+1)'(d);
            m_acc = s[W-1:0];
            q_acc.push_back(m_acc);
            q_car.push_back(s[W]);
            e++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        n_cmp++;
        if (acc !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_acc: got %h want 0000", acc);
        end
        n_cmp++;
        if (carry !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_carry: got %b want 0", carry);
        end
    endtask

    task automatic test_const_4000();
        logic [W-1:0] tbl [4];
        int           n;
        tbl = '{16'h4000, 16'h8000, 16'hC000, 16'h0000};
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(16'h4000, 1'b1);
            if (i < N) begin
                n_cmp++;
                if (valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL const_fill_valid: cycle %0d got %b want 0", i, valid);
                end
            end else begin
                n = i - N;
                n_cmp++;
                if (valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL const_valid: cycle %0d got %b want 1", i, valid);
                end
                n_cmp++;
                if (acc !== tbl[n % 4]) begin
                    n_bad++;
                    $display("FAIL const_acc: sample %0d got %h want %h", n, acc, tbl[n % 4]);
                end
                n_cmp++;
                if (carry !== ((n % 4) == 3)) begin
                    n_bad++;
                    $display("FAIL const_carry: sample %0d got %b want %b", n, carry, (n % 4) == 3);
                end
            end
        end
    endtask

    task automatic test_full_propagate();
        logic [W-1:0] ex_acc [5];
        logic         ex_car [5];
        logic [W-1:0] xin;
        ex_acc = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        ex_car = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < N + 5; i++) begin
            xin = (i == 0) ? 16'hFFFF : ((i == 1) ? 16'h0001 : 16'h0000);
            cyc(xin, 1'b1);
            if (e >= N && e - N < 5) begin
                n_cmp++;
                if (acc !== ex_acc[e-N] || carry !== ex_car[e-N]) begin
                    n_bad++;
                    $display("FAIL propagate: sample %0d got %h/%b want %h/%b",
                             e - N, acc, carry, ex_acc[e-N], ex_car[e-N]);
                end
            end
        end
    endtask

    task automatic test_carry_count();
        int ncar;
        int n;
        ncar = 0;
        do_reset();
        for (int i = 0; i < 64 + N - 1; i++) begin
            cyc((i < 64) ? 16'h1000 : 16'h0000, 1'b1);
            if (e >= N && e - N < 64) begin
                n = e - N;
                if (carry === 1'b1) ncar++;
                n_cmp++;
                if (carry !== ((n % 16) == 15)) begin
                    n_bad++;
                    $display("FAIL carry_pos: sample %0d got %b want %b", n, carry, (n % 16) == 15);
                end
                n_cmp++;
                if (acc !== q_acc[n] || carry !== q_car[n]) begin
                    n_bad++;
                    $display("FAIL carry_model: sample %0d got %h/%b want %h/%b",
                             n, acc, carry, q_acc[n], q_car[n]);
                end
            end
        end
        n_cmp++;
        if (ncar != 4) begin
            n_bad++;
            $display("FAIL carry_count: got %0d want 4", ncar);
        end
    endtask

    task automatic test_random_en();
        logic         ev;
        logic [W-1:0] xv;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            ev = ($urandom_range(0, 9) < 6);
            xv = W'($urandom);
            cyc(xv, ev);
            n_cmp++;
            if (valid !== (e >= N)) begin
                n_bad++;
                $display("FAIL rand_valid: cycle %0d got %b want %b", i, valid, e >= N);
            end
            if (e >= N) begin
                n_cmp++;
                if (acc !== q_acc[e-N] || carry !== q_car[e-N]) begin
                    n_bad++;
                    $display("FAIL rand_out: cycle %0d en %b got %h/%b want %h/%b",
                             i, ev, acc, carry, q_acc[e-N], q_car[e-N]);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(16'h4000, 1'b1);
        // Reset asserted while i_en is low: reset must still win.
        rst = 1'b1;
        en  = 1'b0;
        x   = 16'h4000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        n_cmp++;
        if (valid !== 1'b0 || acc !== 16'h0000 || carry !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got %b/%h/%b want 0/0000/0", valid, acc, carry);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc(16'h4000, 1'b1);
            if (i < N) begin
                n_cmp++;
                if (valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midreset_fill: cycle %0d got %b want 0", i, valid);
                end
            end else if (i == N) begin
                n_cmp++;
                if (valid !== 1'b1 || acc !== 16'h4000) begin
                    n_bad++;
                    $display("FAIL midreset_first: got %b/%h want 1/4000", valid, acc);
                end
            end else if (i == N + 1) begin
                n_cmp++;
                if (acc !== 16'h8000) begin
                    n_bad++;
                    $display("FAIL midreset_second: got %h want 8000", acc);
                end
            end
        end
    endtask

`ifdef PIPE_LCA_DITHER_EN
    task automatic test_dither();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            cyc(16'h0000, 1'b1);
            if (e == N) begin
                n_cmp++;
                if (acc !== 16'h0001) begin
                    n_bad++;
                    $display("FAIL dither_first: got %h want 0001", acc);
                end
            end
            if (e >= N) begin
                n_cmp++;
                if (acc !== q_acc[e-N]) begin
                    n_bad++;
                    $display("FAIL dither_acc: sample %0d got %h want %h", e - N, acc, q_acc[e-N]);
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        x   = '0;
        clear_model();
        test_reset();
`ifdef PIPE_LCA_DITHER_EN
        test_dither();
        test_random_en();
`else
        test_const_4000();
        test_full_propagate();
        test_carry_count();
        test_random_en();
        test_midstream_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_lca_accum.md
# pipe_lca_accum

Parametrised, pipelined carry-lookahead accumulator forming the first-order error-feedback stage of the DDSM datapath. WIDTH-bit accumulation is split into SEG-bit lookahead segments, each segment registered, so the carry chain is one SEG-bit lookahead deep per cycle regardless of WIDTH. Outputs the per-sample overflow bit as the stage's modulator output, plus the aligned accumulator residue for the next MASH stage.

## Interface
- WIDTH, 16: accumulator width; must be an integer multiple of SEG.
- SEG, 4: segment width, i.e. carry-lookahead group size; NSEG = WIDTH/SEG is derived and is at least 1.
- i_clk  input  1  clock; all registers update on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  1  pipeline advance; when low, every register holds, including the dither LFSR.
- i_x  input  WIDTH  unsigned increment, sampled when i_en=1.
- o_acc  output  WIDTH  accumulator residue aligned with o_carry; reset 0.
- o_carry  output  1  overflow, i.e. the modulator output bit; reset 0.
- o_valid  output  1  high once the pipeline has filled; reset 0.

## Operation
- Arithmetic, per enabled sample n:
  - s(n) = acc(n-1) + i_x(n) + d(n), where d is the dither bit (0 when dither is compiled out).
  - acc(n) = s(n) mod 2^WIDTH.
  - o_carry(n) = s(n) >> WIDTH, which is 0 or 1.
  - acc(-1) = 0 after reset. Wrap-around is modulo 2^WIDTH; there is no saturation.
- Segment k (0..NSEG-1) covers bits [k*SEG +: SEG].
  - Each segment uses lookahead carry: generate = a&b and propagate = a|b per bit; carries are computed in parallel within the group.
  - Segment k holds its own SEG-bit sum register.
- Input skew: the slice of i_x for segment k is delayed k enabled cycles.
- Carry registering:
  - The carry-out of segment k is registered and used as the carry-in of segment k+1 on the next enabled cycle.
  - The carry-in of segment 0 is d(n).
- Output deskew: the sum slice of segment k is delayed by an additional NSEG-1-k enabled cycles, so all slices of o_acc belong to the same n.
- o_carry is the registered carry-out of segment NSEG-1.
- Fill counter: o_valid rises after NSEG enabled cycles following reset and then stays high until the next reset. o_acc and o_carry are don't-care while o_valid=0, but are still 0 in practice because every register resets to 0.
- NSEG=1 degenerates to a single-cycle registered adder-accumulator with no skew or deskew registers.

## Timing
- Latency: the sample accepted on enabled edge t appears on o_acc and o_carry after NSEG enabled edges. With i_en held high this is cycle t+NSEG. Throughput is one sample per enabled cycle.
- i_en=0: the whole pipeline freezes and the outputs hold their values. Latency counts enabled edges only.
- Reset:
  - Reset has priority over i_en.
  - Reset mid-operation discards all in-flight samples and clears the sum, carry, skew and deskew registers, o_valid, and the fill counter. The LFSR returns to its seed.
  - On the first cycle after reset deasserts, i_x is accepted as sample 0 if i_en=1.
- Simultaneous carry into a segment plus a full-propagate segment (all ones): the carry ripples by exactly one segment per cycle. There is no combinational path longer than one segment's lookahead plus the carry-in register.

## Configuration
- PIPE_LCA_DITHER_EN defined:
  - Adds a 15-bit Fibonacci LFSR, x^15+x^14+1, with seed 15'h0001 on reset, advancing on each enabled cycle.
  - Its bit 0 is d(n), injected as the segment-0 carry-in.
  - The dither is aligned to sample n in segment 0.
- Not defined: no LFSR is instantiated, d(n)=0, and ports are unchanged.

## Test plan
All scenarios use WIDTH=16, SEG=4 (NSEG=4) and the dither macro undefined unless stated.
- Constant i_x=16'h4000 with i_en=1 from reset -> o_valid rises at cycle 4; o_acc sequence 4000, 8000, C000, 0000, repeating; o_carry=1 on every 4th sample only.
- i_x=16'hFFFF then 16'h0001, then 0 -> o_acc FFFF then 0000; o_carry 0 then 1; o_acc stays 0000 afterwards (checks full 16-bit propagation across all segments).
- i_x=16'h1000 for 64 samples -> exactly 4 carries, at samples 15, 31, 47 and 63. A scoreboard against the reference model s(n) must match every output.
- Random i_x with random i_en gaps -> outputs match the model counted in enabled edges only; outputs are stable throughout i_en=0 stretches.
- Assert i_rst for one cycle mid-stream with i_x=16'h4000 -> the next cycle shows o_valid=0 and o_acc=0; o_valid returns 4 enabled cycles later; the sequence restarts at 4000.
- With PIPE_LCA_DITHER_EN and i_x=0 -> o_acc equals the running count of LFSR bit-0 ones (mod 2^16); first sample d=1, so o_acc=0001.
